// File: rtl/preprocess_hdr_tracker_if.sv
// ---------------------------------------------------------------------------
// preprocess_hdr_tracker_if
// Purpose : datapath word bus feeding the preprocess-stage header tracker.
//           The upstream stage drives the bus (master). The tracker only
//           observes it (slave).
// Signals :
//   in_data  [DATA_WIDTH-1:0]  datapath word
//   in_ctrl  [CTRL_WIDTH-1:0]  0 = data word, !=0 = module header / EOP
//   in_wr                      word valid
// ---------------------------------------------------------------------------
interface preprocess_hdr_tracker_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;

  modport master (output in_data, output in_ctrl, output in_wr);
  modport slave  (input  in_data, input  in_ctrl, input  in_wr);
endinterface

// File: rtl/preprocess_hdr_tracker.sv
// ---------------------------------------------------------------------------
// preprocess_hdr_tracker
// Purpose : follows packets on the datapath bus, skips module headers and
//           raises a one-hot strobe on each of the first NUM_HDR_WORDS data
//           words so that field-extract blocks know which word to sample.
//           Also flags short packets, counts data words per packet and
//           provides a registered in-packet flag.
// Optional feature : define PREPROC_VLAN_DETECT_EN to build the 802.1Q TPID
//           (0x8100) detector on data word 1. Without it vlan_tagged_o is 0.
// Ports :
//   clk                    clock
//   reset                  synchronous, active-high reset
//   in_bus                 datapath bus (slave modport)
//   word_strobe_o          comb, one-hot, bit k = current word is data word k
//   pkt_sop_o              comb, first data word present
//   pkt_eop_o              comb, EOP word of a tracked packet present
//   short_pkt_o            comb, EOP arrived before header word NUM_HDR_WORDS-1
//   in_packet_o            reg, 1 from cycle after SOP to cycle of EOP
//   pkt_word_count_o       reg, data-word count of last packet (incl. EOP)
//   pkt_word_count_vld_o   reg, one-cycle pulse when the count updates
//   vlan_tagged_o          reg, packet carries a VLAN tag (optional feature)
// ---------------------------------------------------------------------------
module preprocess_hdr_tracker #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int NUM_HDR_WORDS = 5,
  parameter int CNT_WIDTH     = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  preprocess_hdr_tracker_if.slave  in_bus,
  output logic [NUM_HDR_WORDS-1:0] word_strobe_o,
  output logic                     pkt_sop_o,
  output logic                     pkt_eop_o,
  output logic                     short_pkt_o,
  output logic                     in_packet_o,
  output logic [CNT_WIDTH-1:0]     pkt_word_count_o,
  output logic                     pkt_word_count_vld_o,
  output logic                     vlan_tagged_o
);

  localparam int HCW = $clog2(NUM_HDR_WORDS);
  localparam logic [HCW-1:0]           LAST_HDR   = HCW'(NUM_HDR_WORDS - 1);
  localparam logic [HCW-1:0]           HDR_ONE    = HCW'(1);
  localparam logic [HCW-1:0]           HDR_ZERO   = {HCW{1'b0}};
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]     CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [NUM_HDR_WORDS-1:0] STROBE_ONE = {{(NUM_HDR_WORDS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [HCW-1:0]           hdr_cnt_q, hdr_cnt_d;
  logic [CNT_WIDTH-1:0]     run_cnt_q, run_cnt_d;
  logic [CNT_WIDTH-1:0]     run_inc_s;
  logic                     in_packet_q, in_packet_d;
  logic [CNT_WIDTH-1:0]     count_q, count_d;
  logic                     vld_q, vld_d;

  logic [DATA_WIDTH-1:0]    data_s;
  logic [CTRL_WIDTH-1:0]    ctrl_s;
  logic                     wr_s;
  logic                     ctrl_nz_s;
  logic [NUM_HDR_WORDS-1:0] strobe_s;
  logic                     sop_s;
  logic                     eop_s;
  logic                     short_s;

  assign data_s    = in_bus.in_data;
  assign ctrl_s    = in_bus.in_ctrl;
  assign wr_s      = in_bus.in_wr;
  assign ctrl_nz_s = |ctrl_s;

  // Saturating increment: a packet longer than the counter reports all-ones.
  assign run_inc_s = (run_cnt_q == CNT_MAX) ? CNT_MAX : (run_cnt_q + CNT_ONE);

  // Next-state and same-cycle strobe decode; gaps (in_wr=0) hold everything.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    run_cnt_d = run_cnt_q;
    strobe_s  = {NUM_HDR_WORDS{1'b0}};
    sop_s     = 1'b0;
    eop_s     = 1'b0;
    short_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Non-zero ctrl while idle is a module header and is skipped.
        if (wr_s && !ctrl_nz_s) begin
          strobe_s  = STROBE_ONE;
          sop_s     = 1'b1;
          hdr_cnt_d = HDR_ONE;
          run_cnt_d = CNT_ONE;
          state_d   = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (wr_s) begin
          strobe_s  = STROBE_ONE << hdr_cnt_q;
          run_cnt_d = run_inc_s;
          if (ctrl_nz_s) begin
            eop_s     = 1'b1;
            // EOP on the last header word still counts as a full header.
            short_s   = (hdr_cnt_q < LAST_HDR);
            hdr_cnt_d = HDR_ZERO;
            state_d   = S_IDLE;
          end else if (hdr_cnt_q == LAST_HDR) begin
            state_d = S_PAYLOAD;
          end else begin
            hdr_cnt_d = hdr_cnt_q + HDR_ONE;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_PAYLOAD: begin
        if (wr_s) begin
          run_cnt_d = run_inc_s;
          if (ctrl_nz_s) begin
            eop_s     = 1'b1;
            hdr_cnt_d = HDR_ZERO;
            state_d   = S_IDLE;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      default: begin
        state_d   = S_IDLE;
        hdr_cnt_d = HDR_ZERO;
        run_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Next values of the registered status outputs.
  always_comb begin
    in_packet_d = in_packet_q;
    count_d     = count_q;
    vld_d       = eop_s;
    if (sop_s) begin
      in_packet_d = 1'b1;
    end else if (eop_s) begin
      in_packet_d = 1'b0;
    end else begin
      in_packet_d = in_packet_q;
    end
    // run_inc_s already folds the EOP word into the count.
    if (eop_s) begin
      count_d = run_inc_s;
    end else begin
      count_d = count_q;
    end
  end

  // FSM, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hdr_cnt_q   <= HDR_ZERO;
      run_cnt_q   <= CNT_ZERO;
      in_packet_q <= 1'b0;
      count_q     <= CNT_ZERO;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      run_cnt_q   <= run_cnt_d;
      in_packet_q <= in_packet_d;
      count_q     <= count_d;
      vld_q       <= vld_d;
    end
  end

`ifdef PREPROC_VLAN_DETECT_EN
  logic vlan_q, vlan_d;
  logic word1_s;

  // Data word 1 is the word carrying the TPID at a 64-bit datapath.
  assign word1_s = (state_q == S_HDR) && wr_s && !ctrl_nz_s && (hdr_cnt_q == HDR_ONE);

  // Tag flag: set after data word 1 matches, cleared by the packet's EOP.
  always_comb begin
    vlan_d = vlan_q;
    if (eop_s) begin
      vlan_d = 1'b0;
    end else if (word1_s && (data_s[31:16] == 16'h8100)) begin
      vlan_d = 1'b1;
    end else begin
      vlan_d = vlan_q;
    end
  end

  // Tag flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vlan_q <= 1'b0;
    end else begin
      vlan_q <= vlan_d;
    end
  end

  assign vlan_tagged_o = vlan_q;
`else
  // Payload bits are not inspected without the tag detector.
  logic unused_data_s;
  assign unused_data_s = ^data_s;
  assign vlan_tagged_o = 1'b0;
`endif

  assign word_strobe_o        = strobe_s;
  assign pkt_sop_o            = sop_s;
  assign pkt_eop_o            = eop_s;
  assign short_pkt_o          = short_s;
  assign in_packet_o          = in_packet_q;
  assign pkt_word_count_o     = count_q;
  assign pkt_word_count_vld_o = vld_q;

endmodule
